// File: rtl/bta_trunc_arb.sv
// bta_trunc_arb: round-robin arbiter in front of one shared lower-bit-truncating
// adder. The granted requester's operands are masked below bit n, added, and the
// result is captured in a one-deep output register drained by valid/ready.

module bta_trunc_arb #(
  parameter int BWOP = 10,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int NABW = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWOP-1:0] req_a,
  input  logic [NREQ*BWOP-1:0] req_b,
  input  logic [NABW-1:0]      cfg_nab,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BWOP-1:0]      out_sum,
  output logic                 out_ovf,
  output logic [IDW-1:0]       out_id,
  output logic [CNTW-1:0]      op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            free;
  logic            transfer;
  logic            accept;

  logic [BWOP-1:0] sel_a;
  logic [BWOP-1:0] sel_b;
  logic [BWOP-1:0] mask;
  logic [BWOP:0]   full_sum;
  logic [BWOP-1:0] sum_next;
  logic            ovf_next;
  logic            trunc_all;

  // Result register state: EMPTY or FULL, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a transfer always fills the register; otherwise a consumer
  // handshake empties it; a full register that is not drained stays full
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (transfer) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (transfer) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Output decode of the result register state
  always_comb begin
    out_valid = (state == FULL);
  end

  // The register can take a new result if it is empty or being drained now
  always_comb begin
    free   = !out_valid || out_ready;
    accept = out_valid && out_ready;
  end

  // Round-robin search: first valid requester starting at ptr, wrapping around
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Grant is one-hot on the winner when the register is free, never during reset
  always_comb begin
    req_ready = '0;
    transfer  = found && free && !rst;
    if (transfer) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Pointer advances past the winner, wrapping at NREQ-1
  always_comb begin
    if (winner == IDW'(NREQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = winner + 1'b1;
    end
  end

  // Round-robin pointer register, moves only on a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= ptr_next;
    end
  end

  // Operand mux selecting the winner's slice of the packed operand buses
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        sel_a = req_a[i*BWOP +: BWOP];
        sel_b = req_b[i*BWOP +: BWOP];
      end
    end
  end

  // Truncating adder: clearing the low n bits of both operands and adding at
  // full width is the same as ((a>>n)+(b>>n))<<n, and the carry lands in bit BWOP
  always_comb begin
    trunc_all = (int'(cfg_nab) >= BWOP);
    mask      = {BWOP{1'b1}} << cfg_nab;
    full_sum  = {1'b0, sel_a & mask} + {1'b0, sel_b & mask};
    if (trunc_all) begin
      sum_next = '0;
      ovf_next = 1'b0;
    end else begin
      sum_next = full_sum[BWOP-1:0];
      ovf_next = full_sum[BWOP];
    end
  end

  // Result payload captures the adder output and requester id on each transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_id  <= '0;
    end else if (transfer) begin
      out_sum <= sum_next;
      out_ovf <= ovf_next;
      out_id  <= winner;
    end
  end

  // Completed-operation counter counts consumer handshakes and wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bta_trunc_arb.sv
// tb_bta_trunc_arb: directed vectors for the truncating-adder arbiter. Stimulus
// pushes hand-computed results into a scoreboard queue; a monitor pops and
// compares whenever the consumer handshake completes.

module tb_bta_trunc_arb;

  localparam int BWOP = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NABW = 4;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BWOP-1:0] req_a;
  logic [NREQ*BWOP-1:0] req_b;
  logic [NABW-1:0]      cfg_nab;
  logic                 out_valid;
  logic                 out_ready;
  logic [BWOP-1:0]      out_sum;
  logic                 out_ovf;
  logic [IDW-1:0]       out_id;
  logic [CNTW-1:0]      op_count;

  logic [BWOP-1:0]      a_op [NREQ];
  logic [BWOP-1:0]      b_op [NREQ];
  logic [BWOP-1:0]      rr_sum [NREQ];
  logic                 rr_ovf [NREQ];

  logic [BWOP+IDW:0]    sb [$];

  int checks = 0;
  int errors = 0;

  bta_trunc_arb #(
    .BWOP(BWOP), .NREQ(NREQ), .IDW(IDW), .NABW(NABW), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .cfg_nab(cfg_nab),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_ovf(out_ovf),
    .out_id(out_id),
    .op_count(op_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NABW-1:0] nab,
                               input logic ordy, input logic r);
    @(posedge clk);
    #1;
    req_valid = valid;
    cfg_nab   = nab;
    out_ready = ordy;
    rst       = r;
    req_a     = {a_op[3], a_op[2], a_op[1], a_op[0]};
    req_b     = {b_op[3], b_op[2], b_op[1], b_op[0]};
  endtask

  task automatic set_op(input int id, input logic [BWOP-1:0] a, input logic [BWOP-1:0] b);
    a_op[id] = a;
    b_op[id] = b;
  endtask

  task automatic expect_result(input int id, input logic [BWOP-1:0] sum, input logic ovf);
    sb.push_back({sum, ovf, IDW'(id)});
  endtask

  // Single-requester operation with a hand-computed result
  task automatic issue(input int id, input logic [BWOP-1:0] a, input logic [BWOP-1:0] b,
                       input logic [NABW-1:0] nab, input logic [BWOP-1:0] sum, input logic ovf);
    logic [NREQ-1:0] one_hot;
    one_hot = '0;
    one_hot[id] = 1'b1;
    set_op(id, a, b);
    applyStimulus(one_hot, nab, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("grant_single", 32'(req_ready), 32'(one_hot));
    expect_result(id, sum, ovf);
  endtask

  // Monitor: every consumer handshake retires the oldest expected result
  initial begin
    logic [BWOP+IDW:0] exp;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got result sum=0x%0h id=%0d expected none", out_sum, out_id);
        end else begin
          exp = sb.pop_front();
          checkOutput("res_sum", 32'(out_sum), 32'(exp[BWOP+IDW:IDW+1]));
          checkOutput("res_ovf", 32'(out_ovf), 32'(exp[IDW]));
          checkOutput("res_id",  32'(out_id),  32'(exp[IDW-1:0]));
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] exp_grant;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    rr_sum[0] = 10'h011; rr_ovf[0] = 1'b0;
    rr_sum[1] = 10'h022; rr_ovf[1] = 1'b0;
    rr_sum[2] = 10'h000; rr_ovf[2] = 1'b1;
    rr_sum[3] = 10'h1FF; rr_ovf[3] = 1'b0;

    rst       = 1'b1;
    req_valid = 4'b0001;
    cfg_nab   = '0;
    out_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;

    // Reset state, with a requester valid to prove no grant during reset
    @(negedge clk);
    checkOutput("rst_ready",    32'(req_ready), 32'h0);
    checkOutput("rst_valid",    32'(out_valid), 32'h0);
    checkOutput("rst_sum",      32'(out_sum),   32'h0);
    checkOutput("rst_ovf",      32'(out_ovf),   32'h0);
    checkOutput("rst_id",       32'(out_id),    32'h0);
    checkOutput("rst_op_count", 32'(op_count),  32'h0);

    // Exact addition and truncating cases, one requester at a time
    issue(0, 10'h0FF, 10'h001, 4'd0,  10'h100, 1'b0);
    issue(2, 10'h007, 10'h005, 4'd2,  10'h008, 1'b0);
    issue(2, 10'h007, 10'h005, 4'd10, 10'h000, 1'b0);
    issue(2, 10'h007, 10'h005, 4'd15, 10'h000, 1'b0);
    issue(1, 10'h3FF, 10'h001, 4'd0,  10'h000, 1'b1);
    issue(1, 10'h3FF, 10'h008, 4'd3,  10'h000, 1'b1);
    applyStimulus(4'b0000, 4'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset so the round-robin pointer restarts at requester 0
    applyStimulus(4'b0000, 4'd0, 1'b1, 1'b1);
    @(negedge clk);

    // All requesters valid: grants rotate 0,1,2,3,0,1 with one result per cycle
    set_op(0, 10'h010, 10'h001);
    set_op(1, 10'h020, 10'h002);
    set_op(2, 10'h200, 10'h200);
    set_op(3, 10'h155, 10'h0AA);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b1111, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      exp_grant = '0;
      exp_grant[k % NREQ] = 1'b1;
      checkOutput("rr_grant", 32'(req_ready), 32'(exp_grant));
      checkOutput("rr_op_count", 32'(op_count), (k == 0) ? 32'd0 : 32'(k - 1));
      expect_result(k % NREQ, rr_sum[k % NREQ], rr_ovf[k % NREQ]);
    end

    // Consumer stalls: no grant and the held result from requester 1 stays put
    for (int h = 0; h < 3; h++) begin
      applyStimulus(4'b1111, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stall_ready", 32'(req_ready), 32'h0);
      checkOutput("stall_valid", 32'(out_valid), 32'h1);
      checkOutput("stall_sum",   32'(out_sum),   32'h022);
      checkOutput("stall_id",    32'(out_id),    32'h1);
    end

    // Stall released: drain and refill in the same cycle, next index is 2
    applyStimulus(4'b1111, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("release_grant", 32'(req_ready), 32'b0100);
    expect_result(2, rr_sum[2], rr_ovf[2]);

    // Grant requester 1 alone so the pointer becomes 2, then hold it unconsumed
    applyStimulus(4'b0010, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("solo_grant", 32'(req_ready), 32'b0010);
    expect_result(1, rr_sum[1], rr_ovf[1]);
    applyStimulus(4'b0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold_valid", 32'(out_valid), 32'h1);
    checkOutput("hold_id",    32'(out_id),    32'h1);

    // Mid-stream reset drops the held result and returns priority to requester 0
    applyStimulus(4'b1111, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_ready", 32'(req_ready), 32'h0);
    sb.delete();
    applyStimulus(4'b1111, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("midrst_valid",    32'(out_valid), 32'h0);
    checkOutput("midrst_op_count", 32'(op_count),  32'h0);
    checkOutput("midrst_grant",    32'(req_ready), 32'b0001);
    expect_result(0, rr_sum[0], rr_ovf[0]);

    applyStimulus(4'b0000, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0000, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("final_op_count", 32'(op_count), 32'h1);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
